// File: rtl/event_irq_controller_if.sv
// Bundle of event inputs, mask write port and CPU interrupt handshake
// between peripherals/CPU (master) and the interrupt controller (slave).
interface event_irq_controller_if #(
  parameter int N  = 4,
  parameter int VW = 2
);
  logic [N-1:0]  src;
  logic          mask_we;
  logic [N-1:0]  mask_in;
  logic          ack;
  logic          eoi;
  logic          irq;
  logic [VW-1:0] vec;
  logic [N-1:0]  pending;
  logic          busy;

  modport master (
    output src, mask_we, mask_in, ack, eoi,
    input  irq, vec, pending, busy
  );

  modport slave (
    input  src, mask_we, mask_in, ack, eoi,
    output irq, vec, pending, busy
  );
endinterface

// File: rtl/event_irq_controller.sv
// Edge-captured event sources with sticky pending flags, fixed-priority
// arbitration and an IDLE/REQ/SERVICE ack + end-of-interrupt sequencer.
module event_irq_controller #(
  parameter int N  = 4,
  parameter int VW = 2
) (
  input logic                clk,
  input logic                rst,
  event_irq_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [N-1:0]  src_q_r;
  logic [N-1:0]  pending_r, pending_nxt_s;
  logic [N-1:0]  mask_r;
  logic          irq_r, irq_nxt_s;
  logic [VW-1:0] vec_r, vec_nxt_s;
  logic          busy_r, busy_nxt_s;

  logic [N-1:0]  edge_s;
  logic [N-1:0]  eligible_s;
  logic [N-1:0]  clr_s;
  logic [VW-1:0] winner_s;
  logic          ack_take_s;

  assign bus.irq     = irq_r;
  assign bus.vec     = vec_r;
  assign bus.pending = pending_r;
  assign bus.busy    = busy_r;

  // Edge detection, lowest-index arbitration and pending set/clear
  always_comb begin
    edge_s        = bus.src & ~src_q_r;
    eligible_s    = pending_r & ~mask_r;
    ack_take_s    = (state_r == REQ) && bus.ack;
    winner_s      = {VW{1'b0}};
    clr_s         = {N{1'b0}};
    // Scan high to low so the lowest eligible index is the last one written
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible_s[i]) begin
        winner_s = VW'(i);
      end else begin
        winner_s = winner_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      clr_s[i] = ack_take_s && (vec_r == VW'(i));
    end
    // A new edge in the same cycle as the ack keeps the flag set
    pending_nxt_s = edge_s | (pending_r & ~clr_s);
  end

  // Sequencer next state and registered output values
  always_comb begin
    state_nxt_s = state_r;
    irq_nxt_s   = irq_r;
    vec_nxt_s   = vec_r;
    case (state_r)
      IDLE: begin
        if (|eligible_s) begin
          vec_nxt_s   = winner_s;
          irq_nxt_s   = 1'b1;
          state_nxt_s = REQ;
        end else begin
          irq_nxt_s   = 1'b0;
        end
      end
      REQ: begin
        if (bus.ack) begin
          irq_nxt_s   = 1'b0;
          state_nxt_s = SERVICE;
        end else begin
          irq_nxt_s   = 1'b1;
        end
      end
      SERVICE: begin
        irq_nxt_s = 1'b0;
        if (bus.eoi) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVICE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        irq_nxt_s   = 1'b0;
        vec_nxt_s   = {VW{1'b0}};
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      src_q_r   <= {N{1'b1}};
      pending_r <= {N{1'b0}};
      mask_r    <= {N{1'b1}};
      irq_r     <= 1'b0;
      vec_r     <= {VW{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      src_q_r   <= bus.src;
      pending_r <= pending_nxt_s;
      if (bus.mask_we) begin
        mask_r <= bus.mask_in;
      end else begin
        mask_r <= mask_r;
      end
      irq_r     <= irq_nxt_s;
      vec_r     <= vec_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_event_irq_controller.sv
// Directed self-checking bench for event_irq_controller (N = 4, VW = 2).
module tb_event_irq_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  event_irq_controller_if #(.N(4), .VW(2)) bus ();

  event_irq_controller #(.N(4), .VW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [3:0] m);
    bus.mask_we = 1'b1;
    bus.mask_in = m;
    tick();
    bus.mask_we = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    bus.src     = 4'b0101;
    bus.mask_we = 1'b0;
    bus.mask_in = 4'b0000;
    bus.ack     = 1'b0;
    bus.eoi     = 1'b0;

    // Reset with sources already high: no spurious pending after release
    repeat (3) tick();
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_vec", 32'(bus.vec), 32'd0);
    rst = 1'b1;
    repeat (2) tick();
    chk("rel_pending", 32'(bus.pending), 32'd0);
    chk("rel_irq", 32'(bus.irq), 32'd0);
    write_mask(4'b0000);
    bus.src = 4'b0100;
    tick();
    bus.src = 4'b0101;
    tick();
    chk("rerise_pending", 32'(bus.pending), 32'h1);
    chk("rerise_irq_early", 32'(bus.irq), 32'd0);
    tick();
    chk("rerise_irq", 32'(bus.irq), 32'd1);
    chk("rerise_vec", 32'(bus.vec), 32'd0);
    chk("rerise_busy", 32'(bus.busy), 32'd1);
    pulse_ack();
    pulse_eoi();
    bus.src = 4'b0000;
    tick();

    // Single event handshake on source 2
    bus.src = 4'b0100;
    tick();
    chk("single_pending", 32'(bus.pending), 32'h4);
    bus.src = 4'b0000;
    tick();
    chk("single_irq", 32'(bus.irq), 32'd1);
    chk("single_vec", 32'(bus.vec), 32'd2);
    pulse_ack();
    chk("single_ack_irq", 32'(bus.irq), 32'd0);
    chk("single_ack_pending", 32'(bus.pending), 32'd0);
    chk("single_ack_busy", 32'(bus.busy), 32'd1);
    pulse_eoi();
    chk("single_eoi_busy", 32'(bus.busy), 32'd0);
    chk("single_eoi_irq", 32'(bus.irq), 32'd0);
    chk("single_eoi_vec_kept", 32'(bus.vec), 32'd2);
    tick();
    chk("single_idle_irq", 32'(bus.irq), 32'd0);

    // Priority: sources 3 and 1 together, 1 wins first
    bus.src = 4'b1010;
    tick();
    chk("prio_pending", 32'(bus.pending), 32'hA);
    bus.src = 4'b0000;
    tick();
    chk("prio_first_irq", 32'(bus.irq), 32'd1);
    chk("prio_first_vec", 32'(bus.vec), 32'd1);
    pulse_ack();
    chk("prio_ack_pending", 32'(bus.pending), 32'h8);
    pulse_eoi();
    chk("prio_eoi_irq", 32'(bus.irq), 32'd0);
    tick();
    chk("prio_second_irq", 32'(bus.irq), 32'd1);
    chk("prio_second_vec", 32'(bus.vec), 32'd3);
    pulse_ack();
    pulse_eoi();
    chk("prio_done_pending", 32'(bus.pending), 32'd0);

    // Masked source still latches pending but does not request
    write_mask(4'b0010);
    bus.src = 4'b0010;
    tick();
    chk("mask_pending", 32'(bus.pending), 32'h2);
    bus.src = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mask_hold_irq", 32'(bus.irq), 32'd0);
    end
    write_mask(4'b0000);
    chk("unmask_irq_early", 32'(bus.irq), 32'd0);
    tick();
    chk("unmask_irq", 32'(bus.irq), 32'd1);
    chk("unmask_vec", 32'(bus.vec), 32'd1);
    pulse_ack();
    pulse_eoi();

    // Ack collides with a fresh edge on the same source
    bus.src = 4'b0001;
    tick();
    bus.src = 4'b0000;
    tick();
    chk("coll_req_vec", 32'(bus.vec), 32'd0);
    chk("coll_req_irq", 32'(bus.irq), 32'd1);
    bus.ack = 1'b1;
    bus.src = 4'b0001;
    tick();
    bus.ack = 1'b0;
    bus.src = 4'b0000;
    chk("coll_pending", 32'(bus.pending), 32'h1);
    chk("coll_irq", 32'(bus.irq), 32'd0);
    pulse_eoi();
    tick();
    chk("coll_rereq_irq", 32'(bus.irq), 32'd1);
    chk("coll_rereq_vec", 32'(bus.vec), 32'd0);
    pulse_ack();
    pulse_eoi();

    // Reset while in SERVICE with source 3 still pending
    bus.src = 4'b1001;
    tick();
    bus.src = 4'b0000;
    tick();
    pulse_ack();
    chk("midrst_pre_pending", 32'(bus.pending), 32'h8);
    chk("midrst_pre_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_pending", 32'(bus.pending), 32'd0);
    chk("midrst_irq", 32'(bus.irq), 32'd0);
    chk("midrst_vec", 32'(bus.vec), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.src = 4'b0001;
    tick();
    bus.src = 4'b0000;
    chk("midrst_new_pending", 32'(bus.pending), 32'h1);
    repeat (3) tick();
    chk("midrst_masked_irq", 32'(bus.irq), 32'd0);
    write_mask(4'b0000);
    tick();
    chk("midrst_unmask_irq", 32'(bus.irq), 32'd1);
    chk("midrst_unmask_vec", 32'(bus.vec), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/event_irq_controller.md
Name: event_irq_controller

Overview:
- Multi-source event capture and interrupt sequencer for the Nano119 CPU.
- Each source input gets a synchronous rising-edge detector with a sticky pending flag.
- A fixed-priority arbiter picks one unmasked pending source. It presents an interrupt request and vector to the CPU, then walks an ack / end-of-interrupt handshake.
- Sits between peripheral strobes (buttons, timers) and the CPU interrupt input.

Parameters:
- N, 4, number of event sources (2..8).
- VW, 2, vector width; must satisfy 2**VW >= N.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on clk rising edge.
- src  input  N  raw event levels, already synchronous to clk.
- mask_we  input  1  write strobe for the mask register.
- mask_in  input  N  new mask value; bit = 1 disables that source's request.
- ack  input  1  CPU accepts the current request; one-cycle pulse.
- eoi  input  1  CPU finished the handler; one-cycle pulse.
- irq  output  1  registered interrupt request to the CPU.
- vec  output  VW  registered index of the requested / in-service source.
- pending  output  N  sticky pending flags, readable as status.
- busy  output  1  high in REQ or SERVICE.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - state = IDLE, pending = 0, mask = all ones (all disabled), src_q = all ones.
  - irq = 0, vec = 0, busy = 0.
  - Applies mid-handshake too: any REQ or SERVICE is abandoned with no residue.
- Edge detect:
  - src_q <= src every cycle.
  - edge[i] = src[i] & ~src_q[i].
  - A source already high when reset releases does not pend until it falls and rises again.
- Pending update per bit, each cycle:
  - Set by edge[i].
  - Cleared when ack is accepted with vec == i.
  - Set and clear in the same cycle: set wins, so pending[i] stays 1.
  - Edges on masked sources still latch pending. Mask only gates arbitration.
- Mask:
  - mask <= mask_in on mask_we.
  - The new value is effective for arbitration from the next cycle.
  - Changing mask during REQ or SERVICE does not withdraw the current request or vector.
- Arbitration: eligible = pending & ~mask. Winner = lowest set index (bit 0 is highest priority).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if eligible != 0, then vec <= winner, irq <= 1, go to REQ. Otherwise stay. ack and eoi are ignored.
  - REQ: irq held 1, vec frozen. On ack: pending[vec] cleared, irq <= 0, go to SERVICE. eoi is ignored.
  - SERVICE: irq = 0, vec still holds the in-service index. On eoi, go to IDLE; vec is retained until the next grant. ack is ignored. New edges keep latching.
  - No nesting: at most one request or service outstanding.
- Latency:
  - src rises in cycle t → pending[i] = 1 in cycle t+1 → irq = 1 in cycle t+2, provided the FSM is IDLE and the source is unmasked.
  - eoi in cycle t → IDLE in t+1 → irq reasserts in t+2 if another eligible source is pending.
- Simultaneous ack and eoi in REQ: ack is honoured, eoi is dropped.
- busy = (state != IDLE), registered with state.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset / no spurious events:
  - Stimulus: hold rst = 0 for 3 cycles with src = 4'b0101, release.
  - Required: irq = 0, pending = 0, busy = 0. Then with mask = 0, drop src[0] and raise it again → pending = 4'b0001, irq = 1 two cycles after the rise, vec = 0.
- Single event handshake (mask = 0):
  - Stimulus: pulse src[2].
  - Required: pending = 4'b0100, irq = 1, vec = 2. Ack → next cycle irq = 0, pending = 0, busy = 1. eoi → busy = 0 and irq stays 0.
- Priority:
  - Stimulus: raise src[3] and src[1] in the same cycle.
  - Required: vec = 1 first. After ack + eoi, irq reasserts 2 cycles after eoi with vec = 3.
- Masking:
  - Stimulus: mask = 4'b0010, pulse src[1].
  - Required: pending = 4'b0010, irq stays 0 for ≥10 cycles. Write mask = 0 → irq = 1, vec = 1 two cycles after mask_we.
- Set/clear collision:
  - Stimulus: in REQ with vec = 0, assert ack in the same cycle src[0] rises again.
  - Required: pending[0] remains 1. After eoi the controller re-requests vec = 0.
- Reset mid-operation:
  - Stimulus: in SERVICE with pending = 4'b1000, assert rst = 0 for 1 cycle.
  - Required: state IDLE, pending = 0, mask = 4'b1111, irq = 0, vec = 0 on the following cycle.
